vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 The block SHALL declare parameter TIMEOUT, default 255, meaning the number of idle cycles in CREDIT before an automatic refund.
REQ-002 The block SHALL declare parameter MAX_CREDIT, default 31, meaning the highest credit held, in units.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port coin, input, 2 bits: coin event. 00 = none, 01 = 1 unit, 10 = 2 units, 11 = invalid and ignored.
REQ-006 Port sel_valid, input, 1 bit: product selection strobe.
REQ-007 Port sel_id, input, 2 bits: selected product index, sampled when sel_valid is high.
REQ-008 Port cancel, input, 1 bit: refund request.
REQ-009 Port stock_empty, input, 4 bits: per-product sold-out flags.
REQ-010 Port disp_req, output, 1 bit: dispense request to the dispense mechanism.
REQ-011 Port disp_id, output, 2 bits: product index to dispense.
REQ-012 Port disp_ack, input, 1 bit: the mechanism has completed the dispense.
REQ-013 Port chg_ready, input, 1 bit: the payout mechanism can accept one unit.
REQ-014 Port chg_pulse, output, 1 bit: pays out one unit of change.
REQ-015 Port credit, output, 5 bits: current credit in units.
REQ-016 Port coin_rej, output, 1 bit: one-cycle pulse when a coin is rejected.
REQ-017 Port err_nostock, output, 1 bit: one-cycle pulse when a sold-out product is selected.
REQ-018 Port err_low, output, 1 bit: one-cycle pulse when a selection has insufficient credit.
REQ-019 Port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 Prices SHALL be fixed at product 0 = 3, product 1 = 4, product 2 = 5 and product 3 = 6 units.
REQ-022 The state machine SHALL have four states: IDLE, CREDIT, DISPENSE and CHANGE.
REQ-023 In IDLE (credit 0), a valid coin SHALL add its value to credit and move to CREDIT.
REQ-024 In IDLE, sel_valid and cancel SHALL be ignored.
REQ-025 In CREDIT, inputs SHALL be evaluated in the priority cancel > sel_valid > timeout.
REQ-026 In CREDIT, cancel SHALL move to CHANGE.
REQ-027 In CREDIT, sel_valid with a stocked product and registered credit >= price SHALL move to DISPENSE with disp_req=1 and disp_id=sel_id on the next cycle, and subtract the price from credit.
REQ-028 In CREDIT, sel_valid for a product whose stock_empty bit is set SHALL pulse err_nostock the next cycle and stay in CREDIT.
REQ-029 In CREDIT, sel_valid with registered credit below the price SHALL pulse err_low the next cycle and stay in CREDIT.
REQ-030 A coin in the same cycle as sel_valid SHALL still be added; the selection SHALL be checked against the pre-coin credit, and the next credit SHALL equal credit + coin - price.
REQ-031 Any coin that would take credit above MAX_CREDIT SHALL be rejected: coin_rej pulses the next cycle and credit is unchanged.
REQ-032 In CREDIT, the idle timer SHALL clear on any coin, sel_valid or cancel.
REQ-033 When the idle timer reaches TIMEOUT cycles in CREDIT, the block SHALL move to CHANGE.
REQ-034 In DISPENSE, disp_req SHALL hold high and disp_id SHALL hold stable until disp_ack is sampled high.
REQ-035 disp_req SHALL deassert in the cycle after disp_ack is sampled high.
REQ-036 After disp_ack, the block SHALL go to IDLE if credit is 0, otherwise to CHANGE.
REQ-037 Coins in DISPENSE SHALL be accepted, subject to REQ-031.
REQ-038 In CHANGE, each cycle with chg_ready=1 SHALL emit one chg_pulse and decrement credit by 1.
REQ-039 chg_pulse SHALL NOT assert while chg_ready=0.
REQ-040 When credit reaches 0 in CHANGE, the block SHALL return to IDLE.
REQ-041 Coins in CHANGE SHALL be rejected via coin_rej.
REQ-042 An illegal state encoding SHALL recover to IDLE with credit 0.

Reset
REQ-043 While rst is high at a rising clk edge, the block SHALL set state = IDLE, credit = 0 and the idle timer = 0.
REQ-044 While rst is high at a rising clk edge, all outputs SHALL be 0.
REQ-045 A reset during DISPENSE or CHANGE SHALL drop disp_req and chg_pulse on the next cycle and discard any remaining credit.

Structure
REQ-046 Package vend_pkg SHALL hold the state enum, the coin encodings, the price table and the credit width.
REQ-047 The idle timer SHALL be a sub-module, vend_idle_timer, with inputs clear and enable and output expired.

Verification
REQ-048 Bench scenario: coins 01, 10, 01 (4 units), then sel 1 -> disp_req=1, disp_id=1; after disp_ack -> IDLE, credit 0, no chg_pulse.
REQ-049 Bench scenario: coins 10, 10, 10 (6 units), then sel 0 -> dispense, then 3 chg_pulse with chg_ready=1 held; with chg_ready low for 2 cycles mid-payout -> pulses pause for those cycles.
REQ-050 Bench scenario: 2 units of credit, then sel 2 -> err_low pulse, credit stays 2; then cancel -> 2 chg_pulse, then IDLE.
REQ-051 Bench scenario: stock_empty=4'b1000, then sel 3 with 6 units -> err_nostock pulse, no disp_req; no activity for TIMEOUT cycles -> 6 chg_pulse.
REQ-052 Bench scenario: credit 30 plus coin 10 -> coin_rej, credit stays 30; sel_valid and coin 01 in the same cycle at credit 3 with sel 0 -> dispense, credit 1.
REQ-053 Bench scenario: rst asserted mid-DISPENSE -> next cycle disp_req=0, credit=0, busy=0.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending controller.
//   - state_t     : controller states
//   - coin_t      : coin input encodings
//   - CREDIT_W    : width of the credit register / credit output
//   - PRICE_TABLE : fixed product prices in credit units, indexed by product id
//   - coin_value  : coin encoding -> value in units (0 for none/invalid)
package vend_pkg;

    localparam int CREDIT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_ONE  = 2'b01,
        COIN_TWO  = 2'b10,
        COIN_BAD  = 2'b11
    } coin_t;

    // Entry [i] is the price of product i: 3, 4, 5, 6 units.
    localparam logic [3:0][CREDIT_W-1:0] PRICE_TABLE = {
        CREDIT_W'(6), CREDIT_W'(5), CREDIT_W'(4), CREDIT_W'(3)
    };

    function automatic logic [1:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_ONE: coin_value = 2'd1;
            COIN_TWO: coin_value = 2'd2;
            default:  coin_value = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if: bundles the vending controller's machine-facing signals.
//   master : the surrounding machine (coin acceptor, keypad, dispenser, payout)
//   slave  : the vend_controller
// Inputs to the controller: coin, sel_valid, sel_id, cancel, stock_empty,
//   disp_ack, chg_ready.
// Outputs from the controller: disp_req, disp_id, chg_pulse, credit,
//   coin_rej, err_nostock, err_low, busy.
interface vend_if;
    import vend_pkg::*;

    logic [1:0]          coin;
    logic                sel_valid;
    logic [1:0]          sel_id;
    logic                cancel;
    logic [3:0]          stock_empty;
    logic                disp_req;
    logic [1:0]          disp_id;
    logic                disp_ack;
    logic                chg_ready;
    logic                chg_pulse;
    logic [CREDIT_W-1:0] credit;
    logic                coin_rej;
    logic                err_nostock;
    logic                err_low;
    logic                busy;

    modport master (
        output coin, sel_valid, sel_id, cancel, stock_empty, disp_ack, chg_ready,
        input  disp_req, disp_id, chg_pulse, credit, coin_rej, err_nostock,
               err_low, busy
    );

    modport slave (
        input  coin, sel_valid, sel_id, cancel, stock_empty, disp_ack, chg_ready,
        output disp_req, disp_id, chg_pulse, credit, coin_rej, err_nostock,
               err_low, busy
    );

endinterface

// File: rtl/vend_idle_timer.sv
// vend_idle_timer: counts idle cycles while enabled and saturates at TIMEOUT.
//   clk, rst : clock, synchronous active-high reset
//   clear    : activity seen this cycle, restart the count
//   enable   : counting allowed (controller is holding credit)
//   expired  : TIMEOUT idle cycles have elapsed
module vend_idle_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;

    assign expired = (count_q == CNT_W'(TIMEOUT));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            count_q <= '0;
        end else if (!expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin-operated vending controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vend_if.slave -- coin/selection/cancel/stock inputs, dispense
//              handshake (disp_req/disp_id/disp_ack), change payout
//              (chg_ready/chg_pulse), credit and one-cycle status pulses.
// All outputs come straight from registers.
module vend_controller
    import vend_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter int MAX_CREDIT = 31
) (
    input  logic   clk,
    input  logic   rst,
    vend_if.slave  bus
);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                disp_req_q, disp_req_d;
    logic [1:0]          disp_id_q, disp_id_d;
    logic                chg_pulse_q, chg_pulse_d;
    logic                coin_rej_q, coin_rej_d;
    logic                err_nostock_q, err_nostock_d;
    logic                err_low_q, err_low_d;
    logic                busy_q, busy_d;

    logic [1:0]          coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_accept;
    logic [CREDIT_W-1:0] credit_add;
    logic [CREDIT_W-1:0] price;
    logic                timer_clear;
    logic                timer_expired;

    // Any valid coin, selection or cancel counts as customer activity.
    assign timer_clear = (coin_val != 2'd0) || bus.sel_valid || bus.cancel;

    vend_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (state_q == ST_CREDIT),
        .expired (timer_expired)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d       = state_q;
        credit_d      = credit_q;
        disp_req_d    = 1'b0;
        disp_id_d     = disp_id_q;
        chg_pulse_d   = 1'b0;
        err_nostock_d = 1'b0;
        err_low_d     = 1'b0;

        coin_val = coin_value(bus.coin);
        coin_sum = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, coin_val};
        price    = PRICE_TABLE[bus.sel_id];

        // Coins are refused while paying out, or when they would overflow
        // the credit limit; the overflow test uses the pre-purchase credit.
        coin_accept = (coin_val != 2'd0) && (state_q != ST_CHANGE) &&
                      (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
        coin_rej_d  = (coin_val != 2'd0) && !coin_accept;
        credit_add  = coin_accept ? coin_sum[CREDIT_W-1:0] : credit_q;

        case (state_q)
            ST_IDLE: begin
                credit_d = credit_add;
                if (coin_accept) state_d = ST_CREDIT;
            end
            ST_CREDIT: begin
                credit_d = credit_add;
                if (bus.cancel) begin
                    state_d = ST_CHANGE;
                end else if (bus.sel_valid) begin
                    // Affordability is judged on the registered credit; a
                    // coin arriving alongside still lands in the new credit.
                    if (bus.stock_empty[bus.sel_id]) begin
                        err_nostock_d = 1'b1;
                    end else if (credit_q < price) begin
                        err_low_d = 1'b1;
                    end else begin
                        state_d    = ST_DISPENSE;
                        disp_req_d = 1'b1;
                        disp_id_d  = bus.sel_id;
                        credit_d   = credit_add - price;
                    end
                end else if (timer_expired && !timer_clear) begin
                    state_d = ST_CHANGE;
                end
            end
            ST_DISPENSE: begin
                credit_d = credit_add;
                if (bus.disp_ack) begin
                    state_d = (credit_add == '0) ? ST_IDLE : ST_CHANGE;
                end else begin
                    disp_req_d = 1'b1;
                end
            end
            ST_CHANGE: begin
                if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else if (bus.chg_ready) begin
                    chg_pulse_d = 1'b1;
                    credit_d    = credit_q - 1'b1;
                    if (credit_q == CREDIT_W'(1)) state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                credit_d   = '0;
                coin_rej_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            disp_req_q    <= 1'b0;
            disp_id_q     <= 2'd0;
            chg_pulse_q   <= 1'b0;
            coin_rej_q    <= 1'b0;
            err_nostock_q <= 1'b0;
            err_low_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_req_q    <= disp_req_d;
            disp_id_q     <= disp_id_d;
            chg_pulse_q   <= chg_pulse_d;
            coin_rej_q    <= coin_rej_d;
            err_nostock_q <= err_nostock_d;
            err_low_q     <= err_low_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.disp_req    = disp_req_q;
    assign bus.disp_id     = disp_id_q;
    assign bus.chg_pulse   = chg_pulse_q;
    assign bus.credit      = credit_q;
    assign bus.coin_rej    = coin_rej_q;
    assign bus.err_nostock = err_nostock_q;
    assign bus.err_low     = err_low_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed scenarios followed by random traffic, every
// cycle compared against a transaction-level model of the vending rules.
module tb_vend_controller;

    localparam int TIMEOUT    = 12;
    localparam int MAX_CREDIT = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vend_if bus ();

    vend_controller #(.TIMEOUT(TIMEOUT), .MAX_CREDIT(MAX_CREDIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int pulses = 0;

    // Model: credit plus "a dispense is outstanding" / "refund in progress"
    // flags; holding credit with neither flag set means waiting for input.
    int   m_credit = 0;
    bit   m_vend   = 1'b0;
    bit   m_refund = 1'b0;
    int   m_idle   = 0;
    int   m_id     = 0;
    bit   e_req, e_pulse, e_rej, e_nostock, e_low;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_step();
        int  cv;
        int  pre;
        int  cost;
        bit  act;
        e_req = 0; e_pulse = 0; e_rej = 0; e_nostock = 0; e_low = 0;
        if (rst) begin
            m_credit = 0; m_vend = 0; m_refund = 0; m_idle = 0; m_id = 0;
            return;
        end
        cv = (bus.coin == 2'b01) ? 1 : (bus.coin == 2'b10) ? 2 : 0;
        if (m_refund) begin
            e_rej = (cv != 0);
            if (m_credit > 0 && bus.chg_ready) begin
                e_pulse = 1;
                m_credit--;
            end
            if (m_credit == 0) m_refund = 0;
            m_idle = 0;
        end else begin
            pre = m_credit;
            if (cv != 0) begin
                if (m_credit + cv <= MAX_CREDIT) m_credit += cv;
                else e_rej = 1;
            end
            if (m_vend) begin
                if (bus.disp_ack) begin
                    m_vend   = 0;
                    m_refund = (m_credit > 0);
                end else begin
                    e_req = 1;
                end
                m_idle = 0;
            end else if (pre > 0) begin
                act = (cv != 0) || bus.sel_valid || bus.cancel;
                if (bus.cancel) begin
                    m_refund = 1;
                end else if (bus.sel_valid) begin
                    cost = 3 + int'(bus.sel_id);
                    if (bus.stock_empty[bus.sel_id]) e_nostock = 1;
                    else if (pre < cost) e_low = 1;
                    else begin
                        m_credit -= cost;
                        m_vend = 1;
                        e_req  = 1;
                        m_id   = int'(bus.sel_id);
                    end
                end else if (!act && m_idle == TIMEOUT) begin
                    m_refund = 1;
                end
                if (act || m_refund || m_vend) m_idle = 0;
                else if (m_idle < TIMEOUT) m_idle++;
            end else begin
                m_idle = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("disp_req",    8'(bus.disp_req),    8'(e_req));
        check("disp_id",     8'(bus.disp_id),     8'(m_id));
        check("chg_pulse",   8'(bus.chg_pulse),   8'(e_pulse));
        check("credit",      8'(bus.credit),      8'(m_credit));
        check("coin_rej",    8'(bus.coin_rej),    8'(e_rej));
        check("err_nostock", 8'(bus.err_nostock), 8'(e_nostock));
        check("err_low",     8'(bus.err_low),     8'(e_low));
        check("busy",        8'(bus.busy),        8'(m_vend || m_refund || m_credit > 0));
        if (bus.chg_pulse) pulses++;
        cycle++;
    endtask

    task automatic drive(input logic [1:0] c, input logic sv, input logic [1:0] sid,
                         input logic can, input logic ack, input logic rdy);
        bus.coin      = c;
        bus.sel_valid = sv;
        bus.sel_id    = sid;
        bus.cancel    = can;
        bus.disp_ack  = ack;
        bus.chg_ready = rdy;
        tick();
    endtask

    task automatic quiet(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        bus.coin = 2'b00; bus.sel_valid = 1'b0; bus.sel_id = 2'd0; bus.cancel = 1'b0;
        bus.stock_empty = 4'b0000; bus.disp_ack = 1'b0; bus.chg_ready = 1'b0;

        // Reset state.
        rst = 1'b1;
        quiet(2, 1'b0);
        rst = 1'b0;

        // 4 units, buy product 1, exact change.
        drive(2'b01, 0, 2'd0, 0, 0, 0);
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        drive(2'b01, 0, 2'd0, 0, 0, 0);
        drive(2'b00, 1, 2'd1, 0, 0, 0);
        check("s1_req", 8'(bus.disp_req), 8'd1);
        check("s1_id",  8'(bus.disp_id),  8'd1);
        drive(2'b00, 0, 2'd0, 0, 0, 0);
        pulses = 0;
        drive(2'b00, 0, 2'd0, 0, 1, 1);
        quiet(3, 1'b1);
        check("s1_idle_busy", 8'(bus.busy), 8'd0);
        check("s1_no_change", 8'(pulses),   8'd0);

        // 6 units, buy product 0, 3 units change with a 2-cycle payout stall.
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        drive(2'b00, 1, 2'd0, 0, 0, 0);
        drive(2'b00, 0, 2'd0, 0, 1, 0);
        pulses = 0;
        drive(2'b00, 0, 2'd0, 0, 0, 1);
        drive(2'b00, 0, 2'd0, 0, 0, 0);
        drive(2'b00, 0, 2'd0, 0, 0, 0);
        check("s2_stall_credit", 8'(bus.credit), 8'd2);
        check("s2_stall_pulses", 8'(pulses),     8'd1);
        quiet(4, 1'b1);
        check("s2_pulses", 8'(pulses), 8'd3);

        // 2 units, product 2 too expensive, then cancel.
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        drive(2'b00, 1, 2'd2, 0, 0, 0);
        check("s3_err_low", 8'(bus.err_low), 8'd1);
        check("s3_credit",  8'(bus.credit),  8'd2);
        pulses = 0;
        drive(2'b00, 0, 2'd0, 1, 0, 0);
        quiet(4, 1'b1);
        check("s3_pulses", 8'(pulses),   8'd2);
        check("s3_idle",   8'(bus.busy), 8'd0);

        // Sold-out product 3, then timeout refund of 6 units.
        bus.stock_empty = 4'b1000;
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        drive(2'b00, 1, 2'd3, 0, 0, 0);
        check("s4_nostock", 8'(bus.err_nostock), 8'd1);
        check("s4_no_req",  8'(bus.disp_req),    8'd0);
        pulses = 0;
        quiet(TIMEOUT + 12, 1'b1);
        check("s4_pulses", 8'(pulses), 8'd6);
        bus.stock_empty = 4'b0000;

        // Overflow reject at 30, then refund.
        for (int i = 0; i < 15; i++) drive(2'b10, 0, 2'd0, 0, 0, 0);
        check("s5_credit30", 8'(bus.credit), 8'd30);
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        check("s5_rej",     8'(bus.coin_rej), 8'd1);
        check("s5_credit",  8'(bus.credit),   8'd30);
        drive(2'b00, 0, 2'd0, 1, 0, 0);
        quiet(32, 1'b1);

        // Coin and selection in the same cycle at credit 3.
        drive(2'b01, 0, 2'd0, 0, 0, 0);
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        drive(2'b01, 1, 2'd0, 0, 0, 0);
        check("s6_req",    8'(bus.disp_req), 8'd1);
        check("s6_credit", 8'(bus.credit),   8'd1);
        drive(2'b00, 0, 2'd0, 0, 1, 1);
        quiet(3, 1'b1);

        // Reset in the middle of a dispense.
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        drive(2'b10, 0, 2'd0, 0, 0, 0);
        drive(2'b00, 1, 2'd0, 0, 0, 0);
        drive(2'b00, 0, 2'd0, 0, 0, 0);
        rst = 1'b1;
        drive(2'b00, 0, 2'd0, 0, 0, 0);
        check("s7_req",    8'(bus.disp_req), 8'd0);
        check("s7_credit", 8'(bus.credit),   8'd0);
        check("s7_busy",   8'(bus.busy),     8'd0);
        rst = 1'b0;

        // Random traffic with periodic quiet stretches to exercise timeouts.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 50) == 0) bus.stock_empty = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 400) == 0);
            if ((i % 400) >= 370) begin
                drive(2'b00, 0, 2'd0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                drive(($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                      ($urandom_range(0, 5) == 0),
                      2'($urandom_range(0, 3)),
                      ($urandom_range(0, 30) == 0),
                      ($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 1)));
            end
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
